// File: rtl/dna_kmer_rolling_hash_pkg.sv
// Shared DNA stream definitions: 2-bit base codes, ASCII letters, hasher state.
package dna_hash_pkg;

    typedef logic [1:0] base_code_t;

    localparam base_code_t CODE_A = 2'd0;
    localparam base_code_t CODE_T = 2'd1;
    localparam base_code_t CODE_C = 2'd2;
    localparam base_code_t CODE_G = 2'd3;

    localparam logic [7:0] ASCII_A_UP = 8'h41;
    localparam logic [7:0] ASCII_T_UP = 8'h54;
    localparam logic [7:0] ASCII_C_UP = 8'h43;
    localparam logic [7:0] ASCII_G_UP = 8'h47;
    localparam logic [7:0] ASCII_A_LO = 8'h61;
    localparam logic [7:0] ASCII_T_LO = 8'h74;
    localparam logic [7:0] ASCII_C_LO = 8'h63;
    localparam logic [7:0] ASCII_G_LO = 8'h67;

    // FILL: fewer than K consecutive valid bases held; FULL: window complete.
    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    // With A=0,T=1,C=2,G=3 the Watson-Crick partner differs only in bit 0.
    function automatic base_code_t complement_code(input base_code_t code);
        return code ^ 2'b01;
    endfunction

endpackage

// File: rtl/dna_kmer_rolling_hash_encoder.sv
// ASCII base to 2-bit code; anything that is not A/C/G/T (either case) is invalid.
module dna_base_encoder
    import dna_hash_pkg::*;
(
    input  logic [7:0] char_in,
    output logic       is_valid,
    output base_code_t code
);

    // Case-insensitive letter decode; N and all other bytes flag invalid.
    always_comb begin
        is_valid = 1'b1;
        code     = CODE_A;
        case (char_in)
            ASCII_A_UP, ASCII_A_LO: code = CODE_A;
            ASCII_T_UP, ASCII_T_LO: code = CODE_T;
            ASCII_C_UP, ASCII_C_LO: code = CODE_C;
            ASCII_G_UP, ASCII_G_LO: code = CODE_G;
            default:                is_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/dna_kmer_rolling_hash.sv
// Streaming rolling k-mer hasher: sliding forward / reverse-complement windows,
// fill tracking across invalid bases, and a single registered output slot.
//
// Handshake: a beat transfers on either interface exactly when valid and ready
// are both high at a rising clk edge; valid never depends on ready, and the
// output holds hash_out/hash_pos stable while hash_valid && !hash_ready.
module dna_kmer_rolling_hash
    import dna_hash_pkg::*;
#(
    parameter  int K         = 4,
    parameter  int CANONICAL = 0,
    parameter  int POS_W     = 32,
    localparam int HASH_W    = 2 * K
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              char_valid,
    output logic              char_ready,
    input  logic [7:0]        char_in,
    input  logic              flush,
    output logic              hash_valid,
    input  logic              hash_ready,
    output logic [HASH_W-1:0] hash_out,
    output logic [POS_W-1:0]  hash_pos
);

    localparam logic [4:0] K_FILL = 5'(K);

    logic                  accept;
    logic                  enc_valid;
    base_code_t            enc_code;

    state_t                state_q, state_d, state_base;
    logic [4:0]            fill_q, fill_d, fill_base, fill_inc;
    logic [HASH_W-1:0]     fwd_q, fwd_d, fwd_base, fwd_new;
    logic [HASH_W-1:0]     rc_q, rc_d, rc_base, rc_new;
    logic [POS_W-1:0]      pos_q, pos_d, pos_base;
    logic [HASH_W+1:0]     fwd_ext;
    logic                  emit;
    logic [HASH_W-1:0]     hash_sel;

    // The output slot frees either because it is empty or because it drains now.
    assign char_ready = !hash_valid || hash_ready;
    assign accept     = char_valid && char_ready;

    dna_base_encoder u_encoder (
        .char_in  (char_in),
        .is_valid (enc_valid),
        .code     (enc_code)
    );

    // Flush takes effect before the accepted base, so build the "base" view of
    // every register first, then apply the base on top of it.
    always_comb begin
        state_base = flush ? ST_FILL : state_q;
        fill_base  = flush ? 5'd0 : fill_q;
        fwd_base   = flush ? '0 : fwd_q;
        rc_base    = flush ? '0 : rc_q;
        pos_base   = flush ? '0 : pos_q;

        fill_inc   = fill_base + 5'd1;
        fwd_ext    = {fwd_base, enc_code};
        fwd_new    = fwd_ext[HASH_W-1:0];
        rc_new     = (rc_base >> 2) | (HASH_W'(complement_code(enc_code)) << (HASH_W - 2));

        fill_d     = fill_base;
        fwd_d      = fwd_base;
        rc_d       = rc_base;
        pos_d      = pos_base;
        if (accept) begin
            pos_d = pos_base + POS_W'(1);
            if (enc_valid) begin
                fwd_d  = fwd_new;
                rc_d   = rc_new;
                fill_d = (fill_base == K_FILL) ? K_FILL : fill_inc;
            end else begin
                fill_d = 5'd0;
            end
        end
    end

    // FSM next state: a valid base completing the window enters FULL, an invalid one drops to FILL.
    always_comb begin
        state_d = state_base;
        case (state_base)
            ST_FILL: begin
                if (accept && enc_valid && fill_inc == K_FILL) state_d = ST_FULL;
            end
            ST_FULL: begin
                if (accept && !enc_valid) state_d = ST_FILL;
            end
            default: state_d = ST_FILL;
        endcase
    end

    // FSM outputs: emit on every valid base that leaves the window complete.
    always_comb begin
        emit = 1'b0;
        case (state_base)
            ST_FILL: emit = accept && enc_valid && (fill_inc == K_FILL);
            ST_FULL: emit = accept && enc_valid;
            default: emit = 1'b0;
        endcase
        hash_sel = fwd_new;
        if (CANONICAL != 0 && rc_new < fwd_new) hash_sel = rc_new;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_FILL;
        else     state_q <= state_d;
    end

    // Window, fill and position registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q <= 5'd0;
            fwd_q  <= '0;
            rc_q   <= '0;
            pos_q  <= '0;
        end else begin
            fill_q <= fill_d;
            fwd_q  <= fwd_d;
            rc_q   <= rc_d;
            pos_q  <= pos_d;
        end
    end

    // Output slot: load on emit, drain on hash_ready, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            hash_valid <= 1'b0;
            hash_out   <= '0;
            hash_pos   <= '0;
        end else if (emit) begin
            hash_valid <= 1'b1;
            hash_out   <= hash_sel;
            hash_pos   <= pos_base;
        end else if (hash_ready) begin
            hash_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dna_kmer_rolling_hash.sv
// Bench for the rolling k-mer hasher: three instances (K=4 forward, K=4
// canonical, K=1 forward) driven by vector tables, directed handshake
// sequences and a randomized K=1 stream against a scoreboard.
module tb_dna_kmer_rolling_hash;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_c = 1'b1;

    // K=4 forward instance
    logic       cv_a = 0, fl_a = 0, hr_a = 1, cr_a, hv_a;
    logic [7:0] ch_a = 0, ho_a;
    logic [31:0] hp_a;
    // K=4 canonical instance
    logic       cv_b = 0, fl_b = 0, hr_b = 1, cr_b, hv_b;
    logic [7:0] ch_b = 0, ho_b;
    logic [31:0] hp_b;
    // K=1 forward instance
    logic       cv_c = 0, fl_c = 0, hr_c = 1, cr_c, hv_c;
    logic [7:0] ch_c = 0;
    logic [1:0] ho_c;
    logic [31:0] hp_c;

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    dna_kmer_rolling_hash #(.K(4), .CANONICAL(0), .POS_W(32)) dut_a (
        .clk(clk), .rst(rst), .char_valid(cv_a), .char_ready(cr_a), .char_in(ch_a),
        .flush(fl_a), .hash_valid(hv_a), .hash_ready(hr_a), .hash_out(ho_a), .hash_pos(hp_a));

    dna_kmer_rolling_hash #(.K(4), .CANONICAL(1), .POS_W(32)) dut_b (
        .clk(clk), .rst(rst), .char_valid(cv_b), .char_ready(cr_b), .char_in(ch_b),
        .flush(fl_b), .hash_valid(hv_b), .hash_ready(hr_b), .hash_out(ho_b), .hash_pos(hp_b));

    dna_kmer_rolling_hash #(.K(1), .CANONICAL(0), .POS_W(32)) dut_c (
        .clk(clk), .rst(rst_c), .char_valid(cv_c), .char_ready(cr_c), .char_in(ch_c),
        .flush(fl_c), .hash_valid(hv_c), .hash_ready(hr_c), .hash_out(ho_c), .hash_pos(hp_c));

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference base code from the letter itself: -1 means not a base.
    function automatic int model_code(input logic [7:0] ch);
        logic [7:0] up;
        up = (ch >= 8'h61 && ch <= 8'h7a) ? ch - 8'h20 : ch;
        if (up == "A") return 0;
        if (up == "T") return 1;
        if (up == "C") return 2;
        if (up == "G") return 3;
        return -1;
    endfunction

    // Collected output handshakes of the K=4 instances.
    logic [7:0] got_h[$];
    int         got_p[$];

    always @(negedge clk) begin
        if (hv_a && hr_a) begin got_h.push_back(ho_a); got_p.push_back(int'(hp_a)); end
        if (hv_b && hr_b) begin got_h.push_back(ho_b); got_p.push_back(int'(hp_b)); end
    end

    // Scoreboard for the K=1 instance: {pos, code} in emission order.
    logic [33:0] exp_q[$];
    logic [31:0] pos_m = 0;

    always @(negedge clk) begin
        if (rst_c) begin
            exp_q.delete();
            pos_m = 0;
        end else begin
            if (hv_c && hr_c) begin
                if (exp_q.size() == 0) check("k1_unexpected_output", {hp_c, ho_c}, 34'h3_ffff_ffff);
                else check("k1_stream", {hp_c, ho_c}, exp_q.pop_front());
            end
            if (cv_c && cr_c && !fl_c) begin
                if (model_code(ch_c) >= 0) exp_q.push_back({pos_m, 2'(model_code(ch_c))});
                pos_m = pos_m + 1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input int which, input logic [7:0] ch, input logic valid, input logic fl);
        if (which == 0) begin cv_a = valid; ch_a = ch; fl_a = fl; end
        else            begin cv_b = valid; ch_b = ch; fl_b = fl; end
        @(posedge clk); #1;
        cv_a = 0; fl_a = 0; cv_b = 0; fl_b = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_str(input int which, input logic [63:0] s, input int len);
        for (int i = 0; i < len; i++) send(which, s[8*(len-1-i) +: 8], 1'b1, 1'b0);
    endtask

    task automatic check_got(input string name, input int idx, input logic [7:0] h, input int p);
        if (idx < got_h.size()) begin
            check({name, "_hash"}, 64'(got_h[idx]), 64'(h));
            check({name, "_pos"}, 64'(got_p[idx]), 64'(p));
        end else begin
            check({name, "_missing"}, 64'(got_h.size()), 64'(idx + 1));
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [63:0]      seq;
        int               len;
        int               which;
        int               cnt;
        logic [2:0][7:0]  eh;
        logic [2:0][31:0] ep;
    } vec_t;

    vec_t vecs[7];

    task automatic set_vec(input int idx, input logic [63:0] seq, input int len, input int which,
                           input int cnt, input logic [7:0] h0, input int p0,
                           input logic [7:0] h1, input int p1, input logic [7:0] h2, input int p2);
        vecs[idx].seq = seq;  vecs[idx].len = len; vecs[idx].which = which; vecs[idx].cnt = cnt;
        vecs[idx].eh[0] = h0; vecs[idx].eh[1] = h1; vecs[idx].eh[2] = h2;
        vecs[idx].ep[0] = p0; vecs[idx].ep[1] = p1; vecs[idx].ep[2] = p2;
    endtask

    logic [7:0] rand_chars[10];

    initial begin
        set_vec(0, "ATCGA",   5, 0, 2, 8'h1B, 3, 8'h6C, 4, 8'h00, 0);
        set_vec(1, "ATNCGTA", 7, 0, 1, 8'hB4, 6, 8'h00, 0, 8'h00, 0);
        set_vec(2, "AAAA",    4, 1, 1, 8'h00, 3, 8'h00, 0, 8'h00, 0);
        set_vec(3, "GGGG",    4, 1, 1, 8'hAA, 3, 8'h00, 0, 8'h00, 0);
        set_vec(4, "gggg",    4, 1, 1, 8'hAA, 3, 8'h00, 0, 8'h00, 0);
        set_vec(5, "GGGG",    4, 0, 1, 8'hFF, 3, 8'h00, 0, 8'h00, 0);
        set_vec(6, "acgtac",  6, 1, 3, 8'h2D, 3, 8'h4B, 4, 8'hD2, 5);
        rand_chars = '{"A", "T", "C", "G", "a", "t", "c", "g", "N", "X"};

        // reset state
        idle(3);
        rst = 0; rst_c = 0;
        @(negedge clk);
        check("rst_hash_valid", 64'(hv_a), 64'd0);
        check("rst_hash_out",   64'(ho_a), 64'd0);
        check("rst_hash_pos",   64'(hp_a), 64'd0);
        check("rst_char_ready", 64'(cr_a), 64'd1);
        check("rst_b_hash_valid", 64'(hv_b), 64'd0);
        check("rst_c_hash_valid", 64'(hv_c), 64'd0);
        @(posedge clk); #1;

        // table-driven vectors
        for (int v = 0; v < 7; v++) begin
            got_h.delete(); got_p.delete();
            send(vecs[v].which, 8'h00, 1'b0, 1'b1);
            send_str(vecs[v].which, vecs[v].seq, vecs[v].len);
            idle(3);
            check($sformatf("vec%0d_count", v), 64'(got_h.size()), 64'(vecs[v].cnt));
            for (int i = 0; i < vecs[v].cnt; i++)
                check_got($sformatf("vec%0d_out%0d", v, i), i, vecs[v].eh[i], int'(vecs[v].ep[i]));
        end

        // latency: output appears the cycle after the completing base
        send(0, 8'h00, 1'b0, 1'b1);
        send_str(0, "ATC", 3);
        @(negedge clk);
        check("lat_before_valid", 64'(hv_a), 64'd0);
        @(posedge clk); #1;
        send(0, "G", 1'b1, 1'b0);
        @(negedge clk);
        check("lat_valid", 64'(hv_a), 64'd1);
        check("lat_hash", 64'(ho_a), 64'h1B);
        check("lat_pos", 64'(hp_a), 64'd3);
        idle(2);

        // backpressure: hold the slot for 5 cycles with a base waiting
        got_h.delete(); got_p.delete();
        hr_a = 0;
        send(0, 8'h00, 1'b0, 1'b1);
        send_str(0, "ATCG", 4);
        cv_a = 1; ch_a = "A";
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_char_ready", 64'(cr_a), 64'd0);
            check("bp_hold_valid", 64'(hv_a), 64'd1);
            check("bp_hold_hash", 64'(ho_a), 64'h1B);
            check("bp_hold_pos", 64'(hp_a), 64'd3);
            @(posedge clk); #1;
        end
        hr_a = 1;
        @(negedge clk);
        check("bp_release_ready", 64'(cr_a), 64'd1);
        @(posedge clk); #1;
        cv_a = 0;
        idle(3);
        check("bp_count", 64'(got_h.size()), 64'd2);
        check_got("bp_out0", 0, 8'h1B, 3);
        check_got("bp_out1", 1, 8'h6C, 4);

        // flush together with an accepted base, output pending at flush time
        got_h.delete(); got_p.delete();
        send(0, 8'h00, 1'b0, 1'b1);
        send_str(0, "ATCG", 4);
        send(0, "A", 1'b1, 1'b1);
        send_str(0, "CG", 2);
        idle(1);
        check("flush_no_early_out", 64'(got_h.size()), 64'd1);
        send(0, "T", 1'b1, 1'b0);
        idle(3);
        check("flush_count", 64'(got_h.size()), 64'd2);
        check_got("flush_pending", 0, 8'h1B, 3);
        check_got("flush_newseq", 1, 8'h2D, 3);

        // flush alone while an output is held keeps the output
        got_h.delete(); got_p.delete();
        hr_a = 0;
        send(0, 8'h00, 1'b0, 1'b1);
        send_str(0, "ATCG", 4);
        send(0, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        check("flush_hold_valid", 64'(hv_a), 64'd1);
        check("flush_hold_hash", 64'(ho_a), 64'h1B);
        @(posedge clk); #1;
        hr_a = 1;
        send_str(0, "ATCG", 4);
        idle(3);
        check("flush_hold_count", 64'(got_h.size()), 64'd2);
        check_got("flush_hold_out0", 0, 8'h1B, 3);
        check_got("flush_hold_out1", 1, 8'h1B, 3);

        // K=1 random stream with backpressure and a mid-stream reset
        for (int i = 0; i < 1000; i++) begin
            if (i == 500) begin
                cv_c = 0; hr_c = 0; rst_c = 1;
                @(posedge clk); #1;
                rst_c = 0;
                @(negedge clk);
                check("k1_rst_valid", 64'(hv_c), 64'd0);
                check("k1_rst_hash", 64'(ho_c), 64'd0);
                check("k1_rst_pos", 64'(hp_c), 64'd0);
                @(posedge clk); #1;
            end
            cv_c = ($urandom_range(0, 3) != 0);
            ch_c = rand_chars[$urandom_range(0, 9)];
            hr_c = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        cv_c = 0; hr_c = 1;
        idle(5);
        check("k1_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
